// File: rtl/codifica_imediato.sv
// Immediate encoder: range-checks a 32-bit immediate for the 12-bit split form or the 19-bit form.
// Feeds a small output FIFO; define CODIFICA_IMEDIATO_CONTA_ERROS_EN to add a saturating error counter.
module codifica_imediato #(
  parameter int PROFUNDIDADE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entr_valido,
  output logic        entr_pronto,
  input  logic [31:0] imed,
  input  logic [1:0]  sel_formato,
  output logic        saida_valido,
  input  logic        saida_pronto,
  output logic [6:0]  saida_parte1,
  output logic [4:0]  saida_parte2,
  output logic [18:0] saida_imed19,
  output logic [1:0]  saida_formato,
`ifdef CODIFICA_IMEDIATO_CONTA_ERROS_EN
  output logic [7:0]  cont_erros,
`endif
  output logic        erro_faixa
);

  localparam int PW = (PROFUNDIDADE > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] PROF_C = CW'(PROFUNDIDADE);
  localparam logic [PW-1:0] ULT_C = PW'(PROFUNDIDADE - 1);

  typedef enum logic {OCIOSO, VERIFICA} estado_t;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [6:0]  p1;
    logic [4:0]  p2;
    logic [18:0] i19;
  } ent_t;

  estado_t       est_q, est_d;
  logic [31:0]   imed_q, imed_d;
  logic [1:0]    fmt_q, fmt_d;
  ent_t          mem_q [PROFUNDIDADE];
  ent_t          mem_d [PROFUNDIDADE];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_en_q, rdy_en_d;

  logic legal, push, pop, aceita;
  ent_t novo, cabeca;

  always_comb begin
    legal = 1'b0;
    novo  = '0;
    case (fmt_q)
      2'd0: begin
        legal    = imed_q[31:11] == {21{imed_q[11]}};
        novo.fmt = 2'd0;
        novo.p1  = imed_q[11:5];
        novo.p2  = imed_q[4:0];
      end
      2'd2: begin
        legal    = imed_q[31:18] == {14{imed_q[18]}};
        novo.fmt = 2'd2;
        novo.i19 = imed_q[18:0];
      end
      default: legal = 1'b0;
    endcase
  end

  // Ready is held off for one edge after reset release.
  assign entr_pronto  = rdy_en_q && (est_q == OCIOSO) && (cnt_q < PROF_C);
  assign aceita       = entr_valido && entr_pronto;
  assign push         = (est_q == VERIFICA) && legal;
  assign erro_faixa   = (est_q == VERIFICA) && !legal;
  assign saida_valido = cnt_q != '0;
  assign pop          = saida_valido && saida_pronto;

  assign cabeca        = saida_valido ? mem_q[rd_q] : '0;
  assign saida_formato = cabeca.fmt;
  assign saida_parte1  = cabeca.p1;
  assign saida_parte2  = cabeca.p2;
  assign saida_imed19  = cabeca.i19;

  always_comb begin
    est_d    = est_q;
    imed_d   = imed_q;
    fmt_d    = fmt_q;
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    rdy_en_d = 1'b1;
    unique case (est_q)
      OCIOSO: begin
        if (aceita) begin
          est_d  = VERIFICA;
          imed_d = imed;
          fmt_d  = sel_formato;
        end
      end
      VERIFICA: est_d = OCIOSO;
    endcase
    if (push) begin
      mem_d[wr_q] = novo;
      wr_d = (wr_q == ULT_C) ? '0 : wr_q + 1'b1;
    end
    if (pop) rd_d = (rd_q == ULT_C) ? '0 : rd_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est_q    <= OCIOSO;
      imed_q   <= '0;
      fmt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
      for (int i = 0; i < PROFUNDIDADE; i++) mem_q[i] <= '0;
    end else begin
      est_q    <= est_d;
      imed_q   <= imed_d;
      fmt_q    <= fmt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= rdy_en_d;
      mem_q    <= mem_d;
    end
  end

`ifdef CODIFICA_IMEDIATO_CONTA_ERROS_EN
  logic [7:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (erro_faixa && cont_q != 8'hFF) cont_d = cont_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cont_q <= '0;
    else     cont_q <= cont_d;
  end

  assign cont_erros = cont_q;
`endif

endmodule

// File: tb/tb_codifica_imediato.sv
// Bench for codifica_imediato: vector table, hand sequences and random traffic vs a queue model.
// Exercises cont_erros when CODIFICA_IMEDIATO_CONTA_ERROS_EN is defined.
module tb_codifica_imediato;

  localparam int PROF = 2;

  logic        clk, rst;
  logic        entr_valido, entr_pronto;
  logic [31:0] imed;
  logic [1:0]  sel_formato;
  logic        saida_valido, saida_pronto;
  logic [6:0]  saida_parte1;
  logic [4:0]  saida_parte2;
  logic [18:0] saida_imed19;
  logic [1:0]  saida_formato;
  logic        erro_faixa;
`ifdef CODIFICA_IMEDIATO_CONTA_ERROS_EN
  logic [7:0]  cont_erros;
`endif

  codifica_imediato #(.PROFUNDIDADE(PROF)) dut (
    .clk(clk), .rst(rst),
    .entr_valido(entr_valido), .entr_pronto(entr_pronto),
    .imed(imed), .sel_formato(sel_formato),
    .saida_valido(saida_valido), .saida_pronto(saida_pronto),
    .saida_parte1(saida_parte1), .saida_parte2(saida_parte2),
    .saida_imed19(saida_imed19), .saida_formato(saida_formato),
`ifdef CODIFICA_IMEDIATO_CONTA_ERROS_EN
    .cont_erros(cont_erros),
`endif
    .erro_faixa(erro_faixa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  p1;
    logic [4:0]  p2;
    logic [18:0] i19;
  } ent_t;

  typedef struct {
    logic [31:0] im;
    logic [1:0]  f;
    logic        err;
    logic [6:0]  p1;
    logic [4:0]  p2;
    logic [18:0] i19;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  ent_t        q[$];
  logic        m_verif, m_rdy_en;
  logic [31:0] m_im;
  logic [1:0]  m_f;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [31:0] im, input logic [1:0] f);
    longint v;
    v = longint'($signed(im));
    if (f == 2'd0) return v >= -2048 && v <= 2047;
    if (f == 2'd2) return v >= -262144 && v <= 262143;
    return 1'b0;
  endfunction

  function automatic ent_t encode(input logic [31:0] im, input logic [1:0] f);
    ent_t e;
    e.fmt = f;
    e.p1 = '0;
    e.p2 = '0;
    e.i19 = '0;
    if (f == 2'd0) begin
      e.p1 = 7'((im / 32) % 128);
      e.p2 = 5'(im % 32);
    end else begin
      e.i19 = 19'(im % 524288);
    end
    return e;
  endfunction

  task automatic model_clear();
    q.delete();
    m_verif = 1'b0;
    m_rdy_en = 1'b0;
    m_im = '0;
    m_f = '0;
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance model.
  task automatic cyc(input logic v, input logic [31:0] im,
                     input logic [1:0] f, input logic pr, output logic acc);
    logic e_rdy, e_err, e_val;
    ent_t h;
    e_rdy = m_rdy_en && !m_verif && (q.size() < PROF);
    e_err = m_verif && !legal(m_im, m_f);
    e_val = q.size() != 0;
    h = '{fmt: 2'd0, p1: 7'd0, p2: 5'd0, i19: 19'd0};
    if (e_val) h = q[0];
    chk("entr_pronto", entr_pronto, e_rdy);
    chk("erro_faixa", erro_faixa, e_err);
    chk("saida_valido", saida_valido, e_val);
    chk("saida_formato", saida_formato, h.fmt);
    chk("saida_parte1", saida_parte1, h.p1);
    chk("saida_parte2", saida_parte2, h.p2);
    chk("saida_imed19", saida_imed19, h.i19);
`ifdef CODIFICA_IMEDIATO_CONTA_ERROS_EN
    chk("cont_erros", cont_erros, m_cnt);
    if (e_err && m_cnt < 255) m_cnt++;
`endif
    entr_valido = v;
    imed = im;
    sel_formato = f;
    saida_pronto = pr;
    acc = v && e_rdy;
    if (e_val && pr) void'(q.pop_front());
    if (m_verif && legal(m_im, m_f)) q.push_back(encode(m_im, m_f));
    m_verif = acc;
    if (acc) begin
      m_im = im;
      m_f = f;
    end
    m_rdy_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_pronto"}, entr_pronto, 0);
    chk({nm, "_valido"}, saida_valido, 0);
    chk({nm, "_erro"}, erro_faixa, 0);
    chk({nm, "_campos"}, {saida_formato, saida_parte1, saida_parte2,
        saida_imed19}, 0);
  endtask

  vec_t vt[10];
  logic acc;
  int   idx;
  int   got[$];
  logic [31:0] rim;
  logic [1:0]  rf;

  initial begin
    m_cnt = 0;
    model_clear();
    rst = 1'b1;
    entr_valido = 1'b0;
    imed = '0;
    sel_formato = '0;
    saida_pronto = 1'b0;

    vt[0] = '{32'hFFFFF800, 2'd0, 1'b0, 7'h40, 5'h00, 19'h0};
    vt[1] = '{32'h00000800, 2'd0, 1'b1, 7'h00, 5'h00, 19'h0};
    vt[2] = '{32'h0003FFFF, 2'd2, 1'b0, 7'h00, 5'h00, 19'h3FFFF};
    vt[3] = '{32'h00040000, 2'd2, 1'b1, 7'h00, 5'h00, 19'h0};
    vt[4] = '{32'h000007FF, 2'd0, 1'b0, 7'h3F, 5'h1F, 19'h0};
    vt[5] = '{32'hFFFFF7FF, 2'd0, 1'b1, 7'h00, 5'h00, 19'h0};
    vt[6] = '{32'hFFFC0000, 2'd2, 1'b0, 7'h00, 5'h00, 19'h40000};
    vt[7] = '{32'hFFFBFFFF, 2'd2, 1'b1, 7'h00, 5'h00, 19'h0};
    vt[8] = '{32'h00000005, 2'd1, 1'b1, 7'h00, 5'h00, 19'h0};
    vt[9] = '{32'h00000123, 2'd3, 1'b1, 7'h00, 5'h00, 19'h0};

    #1;
    chk_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 32'd0, 2'd0, 1'b1, acc);

    foreach (vt[i]) begin
      cyc(1'b1, vt[i].im, vt[i].f, 1'b1, acc);
      chk("vec_aceita", acc, 1);
      chk("vec_erro_n1", erro_faixa, vt[i].err);
      chk("vec_valido_n1", saida_valido, 0);
      cyc(1'b0, 32'd0, 2'd0, 1'b1, acc);
      chk("vec_erro_n2", erro_faixa, 0);
      chk("vec_pronto_n2", entr_pronto, 1);
      chk("vec_valido_n2", saida_valido, !vt[i].err);
      chk("vec_campos", {saida_parte1, saida_parte2, saida_imed19},
          {vt[i].p1, vt[i].p2, vt[i].i19});
      chk("vec_formato", saida_formato, vt[i].err ? 2'd0 : vt[i].f);
      cyc(1'b0, 32'd0, 2'd0, 1'b1, acc);
    end

    // Back-pressure: FIFO fills, then drains in order.
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(idx < 3, 32'(idx + 1), 2'd0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("cheio_pronto", entr_pronto, 0);
    chk("cheio_aceitos", idx, 2);
    for (int c = 0; c < 12; c++) begin
      if (saida_valido) got.push_back(int'(saida_parte2));
      cyc(idx < 3, 32'(idx + 1), 2'd0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("ordem_qtd", got.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) chk("ordem_valor", got[i], i + 1);

    // Reset during VERIFICA discards the entry.
    cyc(1'b1, 32'd5, 2'd0, 1'b1, acc);
    chk("rst_aceita", acc, 1);
    rst = 1'b1;
    #1;
    chk_reset_state("rst_meio");
    model_clear();
    @(negedge clk);
    chk_reset_state("rst_meio2");
    rst = 1'b0;
    for (int c = 0; c < 4; c++) cyc(1'b0, 32'd0, 2'd0, 1'b1, acc);
    chk("rst_pronto_pos", entr_pronto, 1);

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: rim = $urandom;
        1: rim = 32'($urandom_range(0, 5000)) - 32'd2500;
        2: rim = 32'($urandom_range(0, 600000)) - 32'd300000;
        default: rim = ($urandom_range(0, 1) != 0) ? 32'hFFFFF800 : 32'h0003FFFF;
      endcase
      rf = ($urandom_range(0, 7) == 0) ? 2'($urandom) : {$urandom_range(0, 1) != 0, 1'b0};
      cyc($urandom_range(0, 3) != 0, rim, rf, $urandom_range(0, 2) != 0, acc);
    end
    for (int c = 0; c < 6; c++) cyc(1'b0, 32'd0, 2'd0, 1'b1, acc);

`ifdef CODIFICA_IMEDIATO_CONTA_ERROS_EN
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 32'd7, 2'd1, 1'b1, acc);
      cyc(1'b0, 32'd0, 2'd0, 1'b1, acc);
    end
    chk("cont_saturado", cont_erros, 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
